// File: rtl/rc4_pkg.sv
// ---------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 brute-force key search controller.
//   ctrl_state_t    : sequencer states of rc4_key_search_ctrl
//   s_owner_t       : which phase currently owns the single S-memory port
//   ASCII_*         : bounds of the printable plaintext alphabet
//                     (lower-case letters and space)
//   byte_is_legal   : plaintext screen used on every decrypted byte
//   owner_of_state  : maps a sequencer state to the S-port owner
// ---------------------------------------------------------------------------
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_GO,
        ST_INIT_WAIT,
        ST_KSA_GO,
        ST_KSA_WAIT,
        ST_DEC_GO,
        ST_DEC_WAIT,
        ST_NEXT_KEY,
        ST_FOUND,
        ST_EXHAUSTED
    } ctrl_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INIT,
        OWN_KSA,
        OWN_DEC
    } s_owner_t;

    localparam logic [7:0] ASCII_LO    = 8'h61;
    localparam logic [7:0] ASCII_HI    = 8'h7A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // A decrypted byte is plausible plaintext only if it is 'a'..'z' or space.
    function automatic logic byte_is_legal(input logic [7:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SPACE);
    endfunction

    // Both the GO and WAIT state of a phase belong to that phase, so the
    // engine already sees its own bus while its start pulse is high.
    function automatic s_owner_t owner_of_state(input ctrl_state_t s);
        s_owner_t o;
        case (s)
            ST_INIT_GO, ST_INIT_WAIT: o = OWN_INIT;
            ST_KSA_GO,  ST_KSA_WAIT:  o = OWN_KSA;
            ST_DEC_GO,  ST_DEC_WAIT:  o = OWN_DEC;
            default:                  o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rc4_s_port_arbiter.sv
// ---------------------------------------------------------------------------
// rc4_s_port_arbiter
// Purely combinational mux that hands the single S-memory port to the phase
// named by 'owner'. Buses of non-owning phases (including their write
// enables) are ignored; with no owner the port is driven to all zeros.
// Ports:
//   owner                       in  s_owner_t  current port owner
//   init_addr/data/wren         in  8/8/1      S-init engine bus
//   ksa_addr/data/wren          in  8/8/1      key-schedule engine bus
//   dec_addr/data/wren          in  8/8/1      decrypt engine bus
//   s_addr/s_data/s_wren        out 8/8/1      S-memory port
// ---------------------------------------------------------------------------
module rc4_s_port_arbiter
    import rc4_pkg::*;
(
    input  s_owner_t   owner,
    input  logic [7:0] init_addr,
    input  logic [7:0] init_data,
    input  logic       init_wren,
    input  logic [7:0] ksa_addr,
    input  logic [7:0] ksa_data,
    input  logic       ksa_wren,
    input  logic [7:0] dec_addr,
    input  logic [7:0] dec_data,
    input  logic       dec_wren,
    output logic [7:0] s_addr,
    output logic [7:0] s_data,
    output logic       s_wren
);

    always_comb begin
        s_addr = 8'h00;
        s_data = 8'h00;
        s_wren = 1'b0;
        case (owner)
            OWN_INIT: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            OWN_KSA: begin
                s_addr = ksa_addr;
                s_data = ksa_data;
                s_wren = ksa_wren;
            end
            OWN_DEC: begin
                s_addr = dec_addr;
                s_data = dec_data;
                s_wren = dec_wren;
            end
            default: begin
                s_addr = 8'h00;
                s_data = 8'h00;
                s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// rc4_key_search_ctrl
// Top-level sequencer for a brute-force RC4 key search. For every candidate
// key from KEY_FIRST to KEY_LAST it runs S-init, KSA and decrypt in turn,
// grants the single S-memory port to the active phase, screens each
// decrypted byte and either rejects the key (next key / exhausted) or
// reports it as found.
//
// Build option:
//   RC4_FAIL_COUNT_EN  when defined, adds output fail_count, a saturating
//                      count of rejected keys, cleared on reset and start.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle pulse, (re)starts from KEY_FIRST
//   key                        current candidate key
//   init/ksa/dec_start         one-cycle phase start pulses
//   init/ksa/dec_finish        phase done strobes
//   init/ksa/dec_addr,data,wren  S-memory buses from each phase
//   s_addr, s_data, s_wren     arbitrated S-memory port
//   dec_byte, dec_byte_wren    decrypted byte and its write strobe
//   key_is_wrong               abort request to the decrypt engine
//   busy                       search in progress
//   found                      sticky, key holds the valid key
//   exhausted                  sticky, range done without a hit
//   fail_count                 rejected-key count (RC4_FAIL_COUNT_EN only)
// ---------------------------------------------------------------------------
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_FIRST = 24'h000000,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3FFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 dec_start,
    input  logic                 init_finish,
    input  logic                 ksa_finish,
    input  logic                 dec_finish,
    input  logic [7:0]           init_addr,
    input  logic [7:0]           ksa_addr,
    input  logic [7:0]           dec_addr,
    input  logic [7:0]           init_data,
    input  logic [7:0]           ksa_data,
    input  logic [7:0]           dec_data,
    input  logic                 init_wren,
    input  logic                 ksa_wren,
    input  logic                 dec_wren,
    output logic [7:0]           s_addr,
    output logic [7:0]           s_data,
    output logic                 s_wren,
    input  logic [7:0]           dec_byte,
    input  logic                 dec_byte_wren,
    output logic                 key_is_wrong,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted
`ifdef RC4_FAIL_COUNT_EN
    ,
    output logic [KEY_WIDTH-1:0] fail_count
`endif
);

    ctrl_state_t          state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 key_is_wrong_q, key_is_wrong_d;
    logic                 found_q, found_d;
    logic                 exhausted_q, exhausted_d;
    logic                 byte_bad;
    logic                 restart;
    s_owner_t             owner;

    // Only the first illegal byte of a decrypt run matters; once the key is
    // marked wrong further strobes are not screened.
    assign byte_bad = dec_byte_wren && !byte_is_legal(dec_byte) && !key_is_wrong_q;

    // start is honoured only when no search is running.
    assign restart = start &&
                     ((state_q == ST_IDLE) || (state_q == ST_FOUND) ||
                      (state_q == ST_EXHAUSTED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            key_q          <= KEY_FIRST;
            key_is_wrong_q <= 1'b0;
            found_q        <= 1'b0;
            exhausted_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_q          <= key_d;
            key_is_wrong_q <= key_is_wrong_d;
            found_q        <= found_d;
            exhausted_q    <= exhausted_d;
        end
    end

    // Sequencer. Each finish input is only looked at in its own WAIT state,
    // so a decrypt finish that stays high for several cycles is harmless.
    // An illegal byte arriving together with dec_finish still rejects the key.
    always_comb begin
        state_d        = state_q;
        key_d          = key_q;
        key_is_wrong_d = key_is_wrong_q;
        found_d        = found_q;
        exhausted_d    = exhausted_q;
        init_start     = 1'b0;
        ksa_start      = 1'b0;
        dec_start      = 1'b0;

        case (state_q)
            ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                if (restart) begin
                    state_d        = ST_INIT_GO;
                    key_d          = KEY_FIRST;
                    key_is_wrong_d = 1'b0;
                    found_d        = 1'b0;
                    exhausted_d    = 1'b0;
                end
            end
            ST_INIT_GO: begin
                init_start = 1'b1;
                state_d    = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (init_finish) state_d = ST_KSA_GO;
            end
            ST_KSA_GO: begin
                ksa_start = 1'b1;
                state_d   = ST_KSA_WAIT;
            end
            ST_KSA_WAIT: begin
                if (ksa_finish) state_d = ST_DEC_GO;
            end
            ST_DEC_GO: begin
                dec_start = 1'b1;
                state_d   = ST_DEC_WAIT;
            end
            ST_DEC_WAIT: begin
                if (byte_bad) key_is_wrong_d = 1'b1;
                if (dec_finish) begin
                    if (key_is_wrong_q || byte_bad) begin
                        state_d = ST_NEXT_KEY;
                    end else begin
                        state_d = ST_FOUND;
                        found_d = 1'b1;
                    end
                end
            end
            ST_NEXT_KEY: begin
                key_is_wrong_d = 1'b0;
                if (key_q == KEY_LAST) begin
                    state_d     = ST_EXHAUSTED;
                    exhausted_d = 1'b1;
                end else begin
                    key_d   = key_q + KEY_WIDTH'(1);
                    state_d = ST_INIT_GO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign owner        = owner_of_state(state_q);
    assign key          = key_q;
    assign key_is_wrong = key_is_wrong_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_FOUND) &&
                          (state_q != ST_EXHAUSTED);

    rc4_s_port_arbiter u_s_port_arbiter (
        .owner     (owner),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_wren (init_wren),
        .ksa_addr  (ksa_addr),
        .ksa_data  (ksa_data),
        .ksa_wren  (ksa_wren),
        .dec_addr  (dec_addr),
        .dec_data  (dec_data),
        .dec_wren  (dec_wren),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .s_wren    (s_wren)
    );

`ifdef RC4_FAIL_COUNT_EN
    logic [KEY_WIDTH-1:0] fail_count_q, fail_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_count_q <= '0;
        end else begin
            fail_count_q <= fail_count_d;
        end
    end

    // NEXT_KEY lasts exactly one cycle, so one increment per rejected key.
    always_comb begin
        fail_count_d = fail_count_q;
        if (restart) begin
            fail_count_d = '0;
        end else if ((state_q == ST_NEXT_KEY) && (fail_count_q != '1)) begin
            fail_count_d = fail_count_q + KEY_WIDTH'(1);
        end
    end

    assign fail_count = fail_count_q;
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
// Scoreboard bench for rc4_key_search_ctrl with a four-key range (0..3).
// Phase engines are behavioural models answering 5 cycles after their start
// pulse; each drives a fixed S bus (11/A1, 22/B2, 33/C3, wren=1). The decrypt
// model plays a directed byte pattern per key. Expected phase starts,
// key_is_wrong rise times, reset values and final results are queued by the
// stimulus and popped by monitor processes when the DUT shows them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rc4_key_search_ctrl;

    localparam int            KW      = 24;
    localparam logic [KW-1:0] K_FIRST = 24'd0;
    localparam logic [KW-1:0] K_LAST  = 24'd3;

    logic          clk, rst_n, start;
    logic [KW-1:0] key;
    logic          init_start, ksa_start, dec_start;
    logic          init_finish, ksa_finish, dec_finish;
    logic [7:0]    init_addr, ksa_addr, dec_addr;
    logic [7:0]    init_data, ksa_data, dec_data;
    logic          init_wren, ksa_wren, dec_wren;
    logic [7:0]    s_addr, s_data;
    logic          s_wren;
    logic [7:0]    dec_byte;
    logic          dec_byte_wren;
    logic          key_is_wrong, busy, found, exhausted;
    logic [KW-1:0] fc_act;
`ifdef RC4_FAIL_COUNT_EN
    logic [KW-1:0] fail_count;
    assign fc_act = fail_count;
`else
    assign fc_act = '0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0] res_q[$];
    logic [63:0] phase_q[$];
    logic [63:0] rst_q[$];
    int          kiw_q[$];

    // Decrypt-model pattern configuration: pattern B is used for key 'special',
    // pattern A otherwise; bad_* is the index of the first illegal byte (-1: none).
    logic [7:0] pat_a [32];
    logic [7:0] pat_b [32];
    int         len_a, len_b, bad_a, bad_b, special;
    bit         simul_a;

    rc4_key_search_ctrl #(
        .KEY_WIDTH (KW),
        .KEY_FIRST (K_FIRST),
        .KEY_LAST  (K_LAST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key           (key),
        .init_start    (init_start),
        .ksa_start     (ksa_start),
        .dec_start     (dec_start),
        .init_finish   (init_finish),
        .ksa_finish    (ksa_finish),
        .dec_finish    (dec_finish),
        .init_addr     (init_addr),
        .ksa_addr      (ksa_addr),
        .dec_addr      (dec_addr),
        .init_data     (init_data),
        .ksa_data      (ksa_data),
        .dec_data      (dec_data),
        .init_wren     (init_wren),
        .ksa_wren      (ksa_wren),
        .dec_wren      (dec_wren),
        .s_addr        (s_addr),
        .s_data        (s_data),
        .s_wren        (s_wren),
        .dec_byte      (dec_byte),
        .dec_byte_wren (dec_byte_wren),
        .key_is_wrong  (key_is_wrong),
        .busy          (busy),
        .found         (found),
        .exhausted     (exhausted)
`ifdef RC4_FAIL_COUNT_EN
        ,
        .fail_count    (fail_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- expected-value builders ----------------
    function automatic logic [63:0] mk_phase(input logic [1:0] ph, input logic [KW-1:0] k);
        logic [7:0] a, d;
        case (ph)
            2'd1:    begin a = 8'h11; d = 8'hA1; end
            2'd2:    begin a = 8'h22; d = 8'hB2; end
            default: begin a = 8'h33; d = 8'hC3; end
        endcase
        return {21'd0, ph, k, a, d, 1'b1};
    endfunction

    function automatic logic [63:0] mk_res(input bit f, input bit e, input logic [KW-1:0] k,
                                           input logic [KW-1:0] fc);
        logic [KW-1:0] fcx;
`ifdef RC4_FAIL_COUNT_EN
        fcx = fc;
`else
        fcx = '0;
`endif
        return {3'd0, f, e, 1'b0, 1'b0, 8'h00, 1'b0, k, fcx};
    endfunction

    function automatic logic [63:0] rst_exp();
        return {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, K_FIRST, {KW{1'b0}}};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- phase engine models ----------------
    int i_cnt = 0;
    int k_cnt = 0;

    always @(negedge clk) begin
        init_finish = 1'b0;
        if (rst_n !== 1'b1) i_cnt = 0;
        else if (init_start === 1'b1) i_cnt = 5;
        else if (i_cnt > 0) begin
            i_cnt--;
            if (i_cnt == 0) init_finish = 1'b1;
        end
    end

    always @(negedge clk) begin
        ksa_finish = 1'b0;
        if (rst_n !== 1'b1) k_cnt = 0;
        else if (ksa_start === 1'b1) k_cnt = 5;
        else if (k_cnt > 0) begin
            k_cnt--;
            if (k_cnt == 0) ksa_finish = 1'b1;
        end
    end

    // Decrypt model: after dec_start it emits one byte per cycle, stops early
    // once key_is_wrong is seen, then holds dec_finish for two cycles.
    int d_ph  = 0;
    int d_idx = 0;
    bit d_useb = 1'b0;

    always @(negedge clk) begin
        int len, bad;
        bit sim;
        dec_byte_wren = 1'b0;
        dec_finish    = 1'b0;
        len = d_useb ? len_b : len_a;
        bad = d_useb ? bad_b : bad_a;
        sim = d_useb ? 1'b0 : simul_a;
        if (rst_n !== 1'b1) begin
            d_ph = 0;
        end else begin
            case (d_ph)
                0: if (dec_start === 1'b1) begin
                    d_useb = (int'(key) == special);
                    d_idx  = 0;
                    d_ph   = 1;
                end
                1: if ((key_is_wrong === 1'b1) || (d_idx >= len)) begin
                    dec_finish = 1'b1;
                    d_ph       = 2;
                end else begin
                    dec_byte      = d_useb ? pat_b[d_idx] : pat_a[d_idx];
                    dec_byte_wren = 1'b1;
                    if (d_idx == bad) kiw_q.push_back(cyc + 1);
                    if (sim && (d_idx == len - 1)) begin
                        dec_finish = 1'b1;
                        d_ph       = 2;
                    end
                    d_idx++;
                end
                default: begin
                    dec_finish = 1'b1;
                    d_ph       = 0;
                end
            endcase
        end
    end

    // ---------------- monitors ----------------
    bit prev_done = 1'b0;
    bit prev_kiw  = 1'b0;

    task automatic checkPhase(input string name, input logic [1:0] ph);
        logic [63:0] exp;
        exp = (phase_q.size() > 0) ? phase_q.pop_front() : '1;
        checkOutput(name, {21'd0, ph, key, s_addr, s_data, s_wren}, exp);
    endtask

    always @(negedge clk) begin
        bit done_now, kiw_now;
        logic [63:0] exp;
        int kexp;
        done_now = (found === 1'b1) || (exhausted === 1'b1);
        kiw_now  = (key_is_wrong === 1'b1);
        if (done_now && !prev_done) begin
            exp = (res_q.size() > 0) ? res_q.pop_front() : '1;
            checkOutput("search_result", {3'd0, found, exhausted, busy, key_is_wrong, s_addr, s_wren, key, fc_act}, exp);
        end
        if (kiw_now && !prev_kiw) begin
            kexp = (kiw_q.size() > 0) ? kiw_q.pop_front() : -1;
            checkOutput("key_is_wrong_rise_cycle", 64'(cyc), 64'(kexp));
        end
        prev_done = done_now;
        prev_kiw  = kiw_now;
        if (init_start === 1'b1) checkPhase("init_start_key_sport", 2'd1);
        if (ksa_start  === 1'b1) checkPhase("ksa_start_key_sport",  2'd2);
        if (dec_start  === 1'b1) checkPhase("dec_start_key_sport",  2'd3);
    end

    always @(negedge rst_n) begin
        logic [63:0] exp;
        #1;
        exp = (rst_q.size() > 0) ? rst_q.pop_front() : '1;
        checkOutput("reset_state",
                    {5'd0, found, exhausted, busy, key_is_wrong, init_start, ksa_start, dec_start,
                     s_addr, s_data, s_wren, key, fc_act}, exp);
    end

    // ---------------- stimulus helpers ----------------
    task automatic applyStimulus();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pushKey(input int k, input int nph);
        for (int p = 1; p <= nph; p++) phase_q.push_back(mk_phase(2'(p), KW'(k)));
    endtask

    task automatic waitKsa(input int k);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if ((ksa_start === 1'b1) && (int'(key) == k)) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ksa_start: actual=timeout required=ksa_start on key %0d", k);
        end
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while ((res_q.size() != 0) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        if (res_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: actual=no result after %0d cycles required=result", name, n);
            res_q.delete();
            phase_q.delete();
            kiw_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic setA(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                        input int len, input int bad);
        pat_a[0] = b0; pat_a[1] = b1; pat_a[2] = b2;
        pat_a[3] = b3; pat_a[4] = b4; pat_a[5] = b5;
        len_a = len;
        bad_a = bad;
    endtask

    task automatic setFoundOnKey2();
        for (int i = 0; i < 32; i++) pat_b[i] = 8'h61;
        len_b   = 32;
        bad_b   = -1;
        special = 2;
        simul_a = 1'b0;
        setA(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
    endtask

    // Every exhausted run visits keys 0..3 and rejects all four.
    task automatic expectExhausted();
        for (int k = 0; k < 4; k++) pushKey(k, 3);
        res_q.push_back(mk_res(1'b0, 1'b1, 24'd3, 24'd4));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        init_addr = 8'h11; init_data = 8'hA1; init_wren = 1'b1;
        ksa_addr  = 8'h22; ksa_data  = 8'hB2; ksa_wren  = 1'b1;
        dec_addr  = 8'h33; dec_data  = 8'hC3; dec_wren  = 1'b1;
        dec_byte = 8'h00; dec_byte_wren = 1'b0;
        init_finish = 1'b0; ksa_finish = 1'b0; dec_finish = 1'b0;
        special = -1; simul_a = 1'b0; len_b = 0; bad_b = -1;
        setA(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);

        rst_q.push_back(rst_exp());
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Keys 0 and 1 fail on 8'h00, key 2 decrypts to 32 x 'a'.
        // A stray start during the search must be ignored.
        $display("[TB] test 1: found on key 2");
        setFoundOnKey2();
        pushKey(0, 3); pushKey(1, 3); pushKey(2, 3);
        res_q.push_back(mk_res(1'b1, 1'b0, 24'd2, 24'd2));
        applyStimulus();
        waitKsa(1);
        applyStimulus();
        waitDone("t1");

        $display("[TB] test 2: always 8'h7B, exhausted");
        special = -1;
        setA(8'h7B, 8'h7B, 8'h7B, 8'h00, 8'h00, 8'h00, 3, 0);
        expectExhausted();
        applyStimulus();
        waitDone("t2");

        $display("[TB] test 3a: boundary bytes starting at 8'h60");
        setA(8'h60, 8'h61, 8'h7A, 8'h7B, 8'h20, 8'h1F, 6, 0);
        expectExhausted();
        applyStimulus();
        waitDone("t3a");

        $display("[TB] test 3b: boundary bytes starting at 8'h61");
        setA(8'h61, 8'h61, 8'h7A, 8'h7B, 8'h20, 8'h1F, 6, 3);
        expectExhausted();
        applyStimulus();
        waitDone("t3b");

        $display("[TB] test 5: reset during KSA_WAIT of key 1, then restart");
        special = -1;
        setA(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        pushKey(0, 3); pushKey(1, 2);
        applyStimulus();
        waitKsa(1);
        @(negedge clk);
        rst_q.push_back(rst_exp());
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        setFoundOnKey2();
        pushKey(0, 3); pushKey(1, 3); pushKey(2, 3);
        res_q.push_back(mk_res(1'b1, 1'b0, 24'd2, 24'd2));
        applyStimulus();
        waitDone("t5");

        $display("[TB] test 6: illegal byte with dec_finish on key 0");
        setA(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0);
        simul_a = 1'b1;
        pat_b[0] = 8'h61; pat_b[1] = 8'h61;
        len_b = 2; bad_b = -1; special = 1;
        pushKey(0, 3); pushKey(1, 3);
        res_q.push_back(mk_res(1'b1, 1'b0, 24'd1, 24'd1));
        applyStimulus();
        waitDone("t6");

        $display("[TB] test 7: legal edge bytes 7A/20/61 found on key 0");
        simul_a = 1'b0;
        special = -1;
        setA(8'h7A, 8'h20, 8'h61, 8'h00, 8'h00, 8'h00, 3, -1);
        pushKey(0, 3);
        res_q.push_back(mk_res(1'b1, 1'b0, 24'd0, 24'd0));
        applyStimulus();
        waitDone("t7");

        checkOutput("phase_queue_drained", 64'(phase_q.size()), 64'd0);
        checkOutput("kiw_queue_drained",   64'(kiw_q.size()),   64'd0);
        checkOutput("reset_queue_drained", 64'(rst_q.size()),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
